// File: rtl/bit_packer.sv
// MSB-first variable-length bit packer: 0-15 bit fields in, 32-bit words out.
// A 47-bit left-aligned accumulator absorbs one field per cycle; flush emits a zero-padded partial word.
//
// state      | meaning
// RUN        | normal packing; a flush with no full word this cycle emits the residual directly
// FLUSH_PEND | acc_q/count_q hold a residual that must go out this cycle (the slot was taken by a full word)
module bit_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        pushin,
   input  logic [3:0]  lenin,
   input  logic [14:0] datain,
   input  logic        flushin,
   output logic        pushout,
   output logic [31:0] dataout,
   output logic [5:0]  bitsout
);

   typedef enum logic {RUN, FLUSH_PEND} state_t;

   state_t      state_q, state_d;
   logic [46:0] acc_q, acc_d;
   logic [5:0]  count_q, count_d;
   logic        pushout_q, pushout_d;
   logic [31:0] dataout_q, dataout_d;
   logic [5:0]  bitsout_q, bitsout_d;

   logic [14:0] field;
   logic [5:0]  shamt;
   logic [46:0] acc_a;
   logic [5:0]  cnt_a;
   logic        emitted;

   always_comb begin
      state_d   = RUN;
      pushout_d = 1'b0;
      dataout_d = 32'd0;
      bitsout_d = 6'd0;
      acc_a     = acc_q;
      cnt_a     = count_q;
      emitted   = 1'b0;
      field     = datain & ~(15'h7FFF << lenin);

      if (state_q == FLUSH_PEND) begin
         pushout_d = 1'b1;
         dataout_d = acc_q[46:15];
         bitsout_d = count_q;
         acc_a     = 47'd0;
         cnt_a     = 6'd0;
         emitted   = 1'b1;
      end

      // new field lands directly below the cnt_a bits already held
      shamt = 6'd47 - cnt_a - {2'b00, lenin};
      if (pushin && (lenin != 4'd0)) begin
         acc_a = acc_a | ({32'd0, field} << shamt);
         cnt_a = cnt_a + {2'b00, lenin};
      end

      if (cnt_a >= 6'd32) begin
         pushout_d = 1'b1;
         dataout_d = acc_a[46:15];
         bitsout_d = 6'd32;
         acc_a     = acc_a << 32;
         cnt_a     = cnt_a - 6'd32;
         emitted   = 1'b1;
      end

      if (flushin && (cnt_a != 6'd0)) begin
         if (emitted) begin
            state_d = FLUSH_PEND;
         end else begin
            pushout_d = 1'b1;
            dataout_d = acc_a[46:15];
            bitsout_d = cnt_a;
            acc_a     = 47'd0;
            cnt_a     = 6'd0;
         end
      end

      acc_d   = acc_a;
      count_d = cnt_a;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         acc_q     <= 47'd0;
         count_q   <= 6'd0;
         pushout_q <= 1'b0;
         dataout_q <= 32'd0;
         bitsout_q <= 6'd0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         pushout_q <= pushout_d;
         dataout_q <= dataout_d;
         bitsout_q <= bitsout_d;
      end
   end

   assign pushout = pushout_q;
   assign dataout = dataout_q;
   assign bitsout = bitsout_q;

endmodule
